seq_detect_ctrl: RTL

Programmable serial sequence-detector controller. Software or an upstream FSM arms it with a pattern of 1..MAX_LEN bits, an overlap mode and a match target. It then samples serial bit x on x_valid, pulses z on each match, counts matches and signals done when the target is reached. It generalises the fixed 101 detectors in the FSM library into one reusable, sequenced block.

---
 rtl/seq_detect_pkg.sv | 24 ++
 rtl/seq_match_core.sv | 58 +++++
 rtl/seq_detect_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// +-----------------------------------------------------------------+
// | seq_detect_pkg - shared types and sizing for the seq detector   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package seq_detect_pkg;

  localparam int MAX_LEN_DEFAULT = 8;
  localparam int LEN_W           = $clog2(MAX_LEN_DEFAULT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic len_is_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_core.sv
// +-----------------------------------------------------------------+
// | seq_match_core - serial history, fill count and masked compare  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample,
  input  logic               x,
  input  logic               clear,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  output logic               hit
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN:0]   w_shift;
  logic [MAX_LEN-1:0] w_next_hist;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_inc;

  assign w_shift     = {r_hist, x};
  assign w_next_hist = w_shift[MAX_LEN-1:0];
  assign w_fill_inc  = {1'b0, r_fill} + (LEN_W + 1)'(1);

  generate
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
      assign w_mask[i] = (pat_len > LEN_W'(i));
    end
  endgenerate

  // Only bits shifted in since the last clear may take part in a match.
  assign hit = sample
            && (w_fill_inc >= {1'b0, pat_len})
            && (((w_next_hist ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (sample) begin
      r_hist <= w_next_hist;
      r_fill <= (r_fill == LEN_W'(MAX_LEN)) ? r_fill : w_fill_inc[LEN_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
// +-----------------------------------------------------------------+
// | seq_detect_ctrl - programmable serial pattern detector with     |
// | match counting and target completion.  Rev 1.0                  |
// +-----------------------------------------------------------------+
`default_nettype none

module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [MAX_LEN-1:0]           pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic                         overlap,
  input  logic [CNT_W-1:0]             match_target,
  input  logic                         x,
  input  logic                         x_valid,
  output logic                         z,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             match_count,
  output logic                         err
);

  localparam int CFG_LEN_W = $clog2(MAX_LEN + 1);

  state_t                 r_state, w_state_nxt;
  logic [MAX_LEN-1:0]     r_pattern;
  logic [CFG_LEN_W-1:0]   r_len;
  logic                   r_overlap;
  logic [CNT_W-1:0]       r_target;
  logic [CNT_W-1:0]       r_count, w_count_nxt;
  logic                   r_z, w_z;
  logic                   r_err, w_err;
  logic                   w_arm;
  logic                   w_sample;
  logic                   w_clear;
  logic                   w_hit;

  assign w_sample = (r_state == RUN) && x_valid && !abort;
  // Non-overlapping mode restarts the fill so the next match needs fresh bits.
  assign w_clear  = w_arm || (w_hit && !r_overlap);

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (CFG_LEN_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .sample  (w_sample),
    .x       (x),
    .clear   (w_clear),
    .pattern (r_pattern),
    .pat_len (r_len),
    .hit     (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_z         = 1'b0;
    w_err       = 1'b0;
    w_arm       = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (len_is_legal(int'(pat_len), MAX_LEN)) begin
              w_arm       = 1'b1;
              w_count_nxt = '0;
              w_state_nxt = RUN;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        RUN: begin
          if (w_hit) begin
            w_z         = 1'b1;
            w_count_nxt = (r_count == '1) ? r_count : r_count + CNT_W'(1);
            if ((r_target != '0) && (w_count_nxt == r_target)) begin
              w_state_nxt = DONE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_count   <= '0;
      r_z       <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_z     <= w_z;
      r_err   <= w_err;
      if (w_arm) begin
        r_pattern <= pattern;
        r_len     <= pat_len;
        r_overlap <= overlap;
        r_target  <= match_target;
      end
    end
  end

  assign z           = r_z;
  assign err         = r_err;
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign match_count = r_count;

endmodule

`default_nettype wire
